// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between a CPU port and a host port.
// Build option MEM_ARB_RR_EN selects round-robin arbitration; otherwise the CPU wins every tie.
module mem_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 16,
    parameter int unsigned LOCK_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          lock_expired,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned   CW         = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);
    localparam bit            LOCK_EN    = (LOCK_MAX != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_host_q, owner_host_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic          mem_wr_d;
    logic          cpu_gnt_d, host_gnt_d;
    logic          cpu_rvalid_d, host_rvalid_d;
    logic          arb_open, grant;
    logic          lock_honoured, cpu_elig, host_wins;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_expired_d;
    logic [DW-1:0] cpu_rdata_q, host_rdata_q;
`ifdef MEM_ARB_RR_EN
    logic          rr_host_q;
`endif

    // Arbitration: an honoured lock removes the CPU from the contest entirely.
    always_comb begin
        lock_honoured = host_lock & ~lock_expired;
        cpu_elig      = cpu_req & ~lock_honoured;
`ifdef MEM_ARB_RR_EN
        host_wins     = host_req & (~cpu_elig | rr_host_q);
`else
        host_wins     = host_req & ~cpu_elig;
`endif
    end

    assign cpu_hold   = (cpu_req & ~cpu_gnt) | lock_honoured;

    // Read data is forwarded straight from the macro during the response cycle, then held.
    assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
    assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;

    // Next state plus next values of the registered strobes and latched access fields.
    always_comb begin
        state_d       = state_q;
        owner_host_d  = owner_host_q;
        we_d          = we_q;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_wr_d      = 1'b0;
        cpu_gnt_d     = 1'b0;
        host_gnt_d    = 1'b0;
        cpu_rvalid_d  = 1'b0;
        host_rvalid_d = 1'b0;
        arb_open      = 1'b0;
        grant         = 1'b0;

        case (state_q)
            IDLE:    arb_open = 1'b1;
            ACCESS: begin
                state_d       = RESP;
                cpu_rvalid_d  = ~owner_host_q & ~we_q;
                host_rvalid_d = owner_host_q & ~we_q;
            end
            RESP:    arb_open = 1'b1;
            default: state_d = IDLE;
        endcase

        if (arb_open) begin
            grant   = cpu_elig | host_req;
            state_d = grant ? ACCESS : IDLE;
        end

        if (grant) begin
            owner_host_d = host_wins;
            we_d         = host_wins ? host_we    : cpu_we;
            mem_addr_d   = host_wins ? host_addr  : cpu_addr;
            mem_wdata_d  = host_wins ? host_wdata : cpu_wdata;
            mem_wr_d     = we_d;
            cpu_gnt_d    = ~host_wins;
            host_gnt_d   = host_wins;
        end
    end

    // Lock watchdog: counts cycles the CPU is kept waiting by host_lock.
    always_comb begin
        lock_cnt_d     = lock_cnt_q;
        lock_expired_d = lock_expired;
        if (!host_lock) begin
            lock_cnt_d     = '0;
            lock_expired_d = 1'b0;
        end else if (LOCK_EN && cpu_req && (lock_cnt_q != LOCK_LIMIT)) begin
            lock_cnt_d = lock_cnt_q + CW'(1);
            if (lock_cnt_d == LOCK_LIMIT) begin
                lock_expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_host_q <= 1'b0;
            we_q         <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wr       <= 1'b0;
            cpu_gnt      <= 1'b0;
            host_gnt     <= 1'b0;
            cpu_rvalid   <= 1'b0;
            host_rvalid  <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            lock_cnt_q   <= '0;
            lock_expired <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_host_q <= owner_host_d;
            we_q         <= we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_wr       <= mem_wr_d;
            cpu_gnt      <= cpu_gnt_d;
            host_gnt     <= host_gnt_d;
            cpu_rvalid   <= cpu_rvalid_d;
            host_rvalid  <= host_rvalid_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_expired <= lock_expired_d;
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (host_rvalid) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer: after any grant, the other port is favoured next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_host_q <= 1'b0;
        end else if (grant) begin
            rr_host_q <= ~host_wins;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned LM = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_hold, host_gnt, host_rvalid, lock_expired, mem_wr;
    logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [0:1023] = '{default: '0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .lock_expired(lock_expired),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory macro, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one access in flight, grant/response bookkeeping -------------
    logic [DW-1:0] ref_mem [0:1023] = '{default: '0};
    bit            e_gc, e_gh, e_rvc, e_rvh, e_wr;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_rdc = '0, e_rdh = '0, rd_pend = '0;
    bit            acc_host, acc_we, ptr_host, lexp, chk_en;
    int unsigned   lcnt = 0;

    always @(negedge clk) begin : model
        bit hon, cw, hw, wh, in_access;
        bit n_gc, n_gh, n_rvc, n_rvh, n_wr;
        hon = host_lock && !lexp;
        if (chk_en) begin
            chk("cpu_gnt", 32'(cpu_gnt), 32'(e_gc));
            chk("host_gnt", 32'(host_gnt), 32'(e_gh));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rvc));
            chk("host_rvalid", 32'(host_rvalid), 32'(e_rvh));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdc));
            chk("host_rdata", 32'(host_rdata), 32'(e_rdh));
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_wr) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            chk("cpu_hold", 32'(cpu_hold), 32'((cpu_req && !e_gc) || hon));
            chk("lock_expired", 32'(lock_expired), 32'(lexp));
        end
        n_gc = 0; n_gh = 0; n_rvc = 0; n_rvh = 0; n_wr = 0;
        if (!rst_n) begin
            e_addr = '0; e_wdata = '0; e_rdc = '0; e_rdh = '0;
            lcnt = 0; lexp = 0; ptr_host = 0; chk_en = 1;
        end else begin
            in_access = e_gc || e_gh;
            if (in_access && !acc_we) begin
                if (acc_host) begin n_rvh = 1; e_rdh = rd_pend; end
                else begin n_rvc = 1; e_rdc = rd_pend; end
            end
            if (!in_access) begin
                cw = cpu_req && !hon;
                hw = host_req;
                if (cw && hw) wh = RR ? ptr_host : 1'b0;
                else wh = hw;
                if (cw || hw) begin
                    acc_host = wh;
                    acc_we   = wh ? host_we : cpu_we;
                    e_addr   = wh ? host_addr : cpu_addr;
                    e_wdata  = wh ? host_wdata : cpu_wdata;
                    n_gh = wh; n_gc = !wh; n_wr = acc_we;
                    if (acc_we) ref_mem[e_addr] = e_wdata;
                    else rd_pend = ref_mem[e_addr];
                    ptr_host = !wh;
                end
            end
            if (!host_lock) begin
                lcnt = 0; lexp = 0;
            end else if (LM != 0 && cpu_req && lcnt < LM) begin
                lcnt++;
                if (lcnt == LM) lexp = 1;
            end
        end
        e_gc = n_gc; e_gh = n_gh; e_rvc = n_rvc; e_rvh = n_rvh; e_wr = n_wr;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One access from an idle arbiter; entered and left at 1 time unit after a rising edge.
    task automatic access(input bit h, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input string nm);
        int n;
        bit got;
        if (h) begin host_req = 1; host_we = we; host_addr = a; host_wdata = d; end
        else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        got = 0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if ((h ? host_gnt : cpu_gnt) == 1'b1) begin
                got = 1;
                chk({nm, " grant latency"}, 32'(n), 32'd2);
                chk({nm, " mem_addr"}, 32'(mem_addr), 32'(a));
                chk({nm, " mem_wr"}, 32'(mem_wr), 32'(we));
            end
            @(posedge clk);
            #1;
        end
        if (h) host_req = 0; else cpu_req = 0;
        if (!got) begin
            total++; bad++;
            $display("FAIL %s timeout: no grant within 20 cycles", nm);
        end
        @(negedge clk);
        chk({nm, " rvalid"}, 32'(h ? host_rvalid : cpu_rvalid), 32'(!we));
        if (!we) chk({nm, " rdata"}, 32'(h ? host_rdata : cpu_rdata), 32'(exp_rd));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        int k;
        bit cseen, hseen;
        rst_n = 0; cpu_req = 1; host_req = 1; host_lock = 0;
        cpu_we = 0; host_we = 0; cpu_addr = '0; host_addr = '0; cpu_wdata = '0; host_wdata = '0;

        // Reset with both requests high; the first cycle after release is idle, then CPU wins.
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rel cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rel host_gnt", 32'(host_gnt), 32'd0);
        chk("rel rvalid", 32'({cpu_rvalid, host_rvalid}), 32'd0);
        chk("rel mem_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
        chk("rel first grant", 32'({host_gnt, cpu_gnt}), 32'd1);
        @(posedge clk);
        #1 cpu_req = 0; host_req = 0;
        idle(3);

        access(1, 1, 10'h005, 16'hBEEF, 16'h0, "host_wr5");
        access(0, 0, 10'h005, 16'h0, 16'hBEEF, "cpu_rd5");
        access(1, 1, 10'h3FF, 16'h1234, 16'h0, "host_wr3ff");
        access(1, 0, 10'h3FF, 16'h0, 16'h1234, "host_rd3ff");
        access(0, 1, 10'h3FF, 16'hA5A5, 16'h0, "cpu_wr3ff");
        access(1, 0, 10'h3FF, 16'h0, 16'hA5A5, "host_rd3ff_b");

        // Both ports requesting continuously.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h001;
        host_req = 1; host_we = 0; host_addr = 10'h002;
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
            @(negedge clk);
            if (cpu_gnt || host_gnt) begin
                chk($sformatf("tie grant %0d", k), 32'({host_gnt, cpu_gnt}),
                    (RR && (k % 2 == 1)) ? 32'd2 : 32'd1);
                k++;
            end
            @(posedge clk);
            #1;
        end
        cpu_req = 0; host_req = 0;
        chk("tie grant count", 32'(k), 32'd6);
        idle(3);

        // Host lock against a waiting CPU read, expiring after LM cycles.
        host_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("lock hold %0d", i), 32'(cpu_hold), 32'd1);
            chk($sformatf("lock no gnt %0d", i), 32'(cpu_gnt), 32'd0);
            chk($sformatf("lock not expired %0d", i), 32'(lock_expired), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("lock expired", 32'(lock_expired), 32'd1);
        chk("lock expired no gnt yet", 32'(cpu_gnt), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lock cpu gnt after expiry", 32'(cpu_gnt), 32'd1);
        @(posedge clk);
        #1 cpu_req = 0; host_lock = 0;
        idle(1);
        @(negedge clk);
        chk("lock expired cleared", 32'(lock_expired), 32'd0);
        idle(3);

        // Reset asserted during the access cycle of a CPU read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        @(posedge clk);
        #1 rst_n = 0; cpu_req = 0;
        @(negedge clk);
        chk("midrst access gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst no rvalid %0d", i), 32'(cpu_rvalid), 32'd0);
            @(posedge clk);
            #1;
        end
        access(0, 0, 10'h005, 16'h0, 16'hBEEF, "post_rst_rd");

        // Randomized traffic with protocol-correct requesters, lock toggling and rare resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cseen = cpu_gnt;
            hseen = host_gnt;
            @(posedge clk);
            #1;
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 199) == 0) rst_n = 0;
            if (!cpu_req || cseen) begin
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = rnd_addr();
                cpu_wdata = DW'($urandom);
            end
            if (!host_req || hseen) begin
                host_req   = ($urandom_range(0, 99) < 45);
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = rnd_addr();
                host_wdata = DW'($urandom);
            end
            if ($urandom_range(0, 29) == 0) host_lock = !host_lock;
        end
        cpu_req = 0; host_req = 0; host_lock = 0; rst_n = 1;
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
